// File: rtl/rv_wb_trace_monitor.sv
// Writeback monitor for the rv32i pipeline: timestamps register-file writes into a
// show-ahead trace FIFO, decides pass/timeout, and counts accepted and dropped events.
module rv_wb_trace_monitor #(
   parameter int XLEN        = 32,
   parameter int DEPTH       = 16,
   parameter int CYC_W       = 16,
   parameter int TIMEOUT_CYC = 100,
   parameter int DONE_REG    = 10,
   parameter int DONE_VAL    = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_wb_en,
   input  logic [4:0]       i_wb_rd,
   input  logic [XLEN-1:0]  i_wb_data,
   output logic             o_trc_valid,
   input  logic             i_trc_ready,
   output logic [4:0]       o_trc_rd,
   output logic [XLEN-1:0]  o_trc_data,
   output logic [CYC_W-1:0] o_trc_cycle,
   output logic [1:0]       o_state,
   output logic             o_pass,
   output logic [15:0]      o_wr_count,
   output logic [7:0]       o_drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 5 + XLEN + CYC_W;
   localparam logic [4:0]       DONE_RD   = 5'(DONE_REG);
   localparam logic [XLEN-1:0]  DONE_DATA = XLEN'(DONE_VAL);
   localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_DONE    = 2'b01,
      ST_TIMEOUT = 2'b10
   } state_e;

   state_e           state_q;
   logic             pass_q;
   logic [CYC_W-1:0] cyc_q;

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [EW-1:0]    mem_q [DEPTH];
   logic [EW-1:0]    head_q, head_d;
   logic             valid_q;
   logic [15:0]      wr_cnt_q, wr_cnt_d;
   logic [7:0]       drop_cnt_q, drop_cnt_d;

   logic             accept, done_hit, full, pop, push, drop;
   logic [EW-1:0]    push_ent;

   assign accept   = i_wb_en && (i_wb_rd != 5'd0) && (state_q == ST_RUN);
   assign done_hit = accept && (i_wb_rd == DONE_RD) && (i_wb_data == DONE_DATA);
   assign push_ent = {i_wb_rd, i_wb_data, cyc_q};

   // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
   assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop  = valid_q && i_trc_ready;
   assign push = accept && (!full || pop);
   assign drop = accept && full && !pop;

   assign wr_ptr_d = wr_ptr_q + (AW+1)'(push);
   assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop);

   // Next head: empty -> zeros; head is the slot being written now -> bypass the input.
   always_comb begin
      head_d = '0;
      if (rd_ptr_d == wr_ptr_d) begin
         head_d = '0;
      end else if (rd_ptr_d == wr_ptr_q) begin
         head_d = push_ent;
      end else begin
         head_d = mem_q[rd_ptr_d[AW-1:0]];
      end
   end

   assign wr_cnt_d   = (accept && (wr_cnt_q != 16'hFFFF)) ? wr_cnt_q + 16'd1 : wr_cnt_q;
   assign drop_cnt_d = (drop && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;

   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_ent;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         head_q     <= '0;
         valid_q    <= 1'b0;
         wr_cnt_q   <= '0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         head_q     <= head_d;
         valid_q    <= (rd_ptr_d != wr_ptr_d);
         wr_cnt_q   <= wr_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Pass/timeout FSM; a done write in the final RUN cycle still wins over timeout.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_RUN;
         pass_q  <= 1'b0;
         cyc_q   <= '0;
      end else begin
         case (state_q)
            ST_RUN: begin
               cyc_q <= cyc_q + CYC_W'(1);
               if (done_hit) begin
                  state_q <= ST_DONE;
                  pass_q  <= 1'b1;
               end else if (cyc_q == CYC_LAST) begin
                  state_q <= ST_TIMEOUT;
               end
            end
            default: begin
               state_q <= state_q;
            end
         endcase
      end
   end

   assign o_trc_valid  = valid_q;
   assign o_trc_rd     = head_q[EW-1 -: 5];
   assign o_trc_data   = head_q[CYC_W +: XLEN];
   assign o_trc_cycle  = head_q[CYC_W-1:0];
   assign o_state      = state_q;
   assign o_pass       = pass_q;
   assign o_wr_count   = wr_cnt_q;
   assign o_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_rv_wb_trace_monitor.sv
// Bench for rv_wb_trace_monitor: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a queue-based model of the monitor.
module tb_rv_wb_trace_monitor;

   localparam int XLEN  = 32;
   localparam int DEPTH = 16;
   localparam int CYC_W = 16;
   localparam int TMO   = 100;

   logic             clk = 1'b0;
   logic             i_rst;
   logic             i_wb_en;
   logic [4:0]       i_wb_rd;
   logic [XLEN-1:0]  i_wb_data;
   logic             o_trc_valid;
   logic             i_trc_ready;
   logic [4:0]       o_trc_rd;
   logic [XLEN-1:0]  o_trc_data;
   logic [CYC_W-1:0] o_trc_cycle;
   logic [1:0]       o_state;
   logic             o_pass;
   logic [15:0]      o_wr_count;
   logic [7:0]       o_drop_count;

   always #5 clk = ~clk;

   rv_wb_trace_monitor #(
      .XLEN(XLEN), .DEPTH(DEPTH), .CYC_W(CYC_W),
      .TIMEOUT_CYC(TMO), .DONE_REG(10), .DONE_VAL(1)
   ) dut (
      .i_clk(clk), .i_rst(i_rst),
      .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
      .o_trc_valid(o_trc_valid), .i_trc_ready(i_trc_ready),
      .o_trc_rd(o_trc_rd), .o_trc_data(o_trc_data), .o_trc_cycle(o_trc_cycle),
      .o_state(o_state), .o_pass(o_pass),
      .o_wr_count(o_wr_count), .o_drop_count(o_drop_count)
   );

   typedef struct {
      logic [4:0]       rd;
      logic [XLEN-1:0]  data;
      logic [CYC_W-1:0] cyc;
   } ent_t;

   ent_t mq[$];
   ent_t obs[$];
   int   m_cycle, m_state, m_wr, m_drop;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("valid", 64'(o_trc_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("head_rd", 64'(o_trc_rd), 64'(mq[0].rd));
         chk("head_data", 64'(o_trc_data), 64'(mq[0].data));
         chk("head_cycle", 64'(o_trc_cycle), 64'(mq[0].cyc));
      end
      chk("state", 64'(o_state), 64'(m_state));
      chk("pass", 64'(o_pass), 64'(m_state == 1));
      chk("wr_count", 64'(o_wr_count), 64'(m_wr));
      chk("drop_count", 64'(o_drop_count), 64'(m_drop));
   endtask

   // One clock: drive inputs, advance the model from the pre-edge state, check after the edge.
   task automatic step(input logic en, input logic [4:0] rd, input logic [XLEN-1:0] data,
                       input logic rdy);
      bit acc, popped, was_full;
      i_wb_en     = en;
      i_wb_rd     = rd;
      i_wb_data   = data;
      i_trc_ready = rdy;
      acc      = en && (rd != 5'd0) && (m_state == 0);
      popped   = (mq.size() != 0) && rdy;
      was_full = (mq.size() == DEPTH);
      if (popped) begin
         obs.push_back('{o_trc_rd, o_trc_data, o_trc_cycle});
         void'(mq.pop_front());
      end
      if (acc) begin
         if (m_wr < 65535) m_wr++;
         if (!was_full || popped) mq.push_back('{rd, data, CYC_W'(m_cycle)});
         else if (m_drop < 255) m_drop++;
      end
      if (m_state == 0) begin
         if (acc && rd == 5'd10 && data == 32'd1) m_state = 1;
         else if (m_cycle == TMO - 1) m_state = 2;
         m_cycle++;
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      i_rst       = 1'b1;
      i_wb_en     = 1'b0;
      i_wb_rd     = '0;
      i_wb_data   = '0;
      i_trc_ready = 1'b0;
      @(posedge clk);
      #1;
      m_cycle = 0;
      m_state = 0;
      m_wr    = 0;
      m_drop  = 0;
      mq.delete();
      obs.delete();
      check_all();
      chk("rst_rd", 64'(o_trc_rd), 64'd0);
      chk("rst_data", 64'(o_trc_data), 64'd0);
      chk("rst_cycle", 64'(o_trc_cycle), 64'd0);
      i_rst = 1'b0;
   endtask

   initial begin
      // Idle run times out at cycle 99.
      do_reset();
      repeat (99) step(1'b0, 5'd0, 32'd0, 1'b1);
      chk("idle_still_run", 64'(o_state), 64'd0);
      step(1'b0, 5'd0, 32'd0, 1'b1);
      chk("idle_timeout", 64'(o_state), 64'd2);
      chk("idle_pass", 64'(o_pass), 64'd0);
      chk("idle_valid", 64'(o_trc_valid), 64'd0);
      chk("idle_wr", 64'(o_wr_count), 64'd0);
      repeat (5) step(1'b1, 5'd10, 32'd1, 1'b1);
      chk("timeout_terminal", 64'(o_state), 64'd2);

      // Basic trace ordering, x0 filtered.
      do_reset();
      repeat (2) step(1'b0, 5'd0, 32'd0, 1'b1);
      step(1'b1, 5'd7, 32'd5, 1'b1);
      step(1'b1, 5'd0, 32'd9, 1'b1);
      step(1'b1, 5'd8, 32'd6, 1'b1);
      repeat (3) step(1'b0, 5'd0, 32'd0, 1'b1);
      chk("basic_n", 64'(obs.size()), 64'd2);
      if (obs.size() == 2) begin
         chk("basic0", {obs[0].rd, obs[0].data, obs[0].cyc}, {5'd7, 32'd5, 16'd2});
         chk("basic1", {obs[1].rd, obs[1].data, obs[1].cyc}, {5'd8, 32'd6, 16'd4});
      end
      chk("basic_wr", 64'(o_wr_count), 64'd2);

      // Done write at cycle 20; later writes ignored.
      do_reset();
      repeat (20) step(1'b0, 5'd0, 32'd0, 1'b0);
      step(1'b1, 5'd10, 32'd1, 1'b0);
      chk("done_state", 64'(o_state), 64'd1);
      chk("done_pass", 64'(o_pass), 64'd1);
      chk("done_entry", {o_trc_rd, o_trc_data, o_trc_cycle}, {5'd10, 32'd1, 16'd20});
      step(1'b1, 5'd9, 32'd3, 1'b0);
      chk("done_ignored_wr", 64'(o_wr_count), 64'd1);
      repeat (3) step(1'b0, 5'd0, 32'd0, 1'b1);
      chk("done_drained", 64'(o_trc_valid), 64'd0);

      // Done and timeout in the same cycle.
      do_reset();
      repeat (99) step(1'b0, 5'd0, 32'd0, 1'b1);
      step(1'b1, 5'd10, 32'd1, 1'b1);
      chk("race_state", 64'(o_state), 64'd1);
      chk("race_pass", 64'(o_pass), 64'd1);

      // Overflow: 20 writes with no consumer.
      do_reset();
      for (int i = 1; i <= 20; i++) step(1'b1, 5'(i), 32'(i), 1'b0);
      chk("ovf_drop", 64'(o_drop_count), 64'd4);
      chk("ovf_wr", 64'(o_wr_count), 64'd20);
      obs.delete();
      repeat (17) step(1'b0, 5'd0, 32'd0, 1'b1);
      chk("ovf_n", 64'(obs.size()), 64'd16);
      for (int k = 0; k < obs.size(); k++) chk("ovf_order", 64'(obs[k].rd), 64'(k + 1));
      chk("ovf_empty", 64'(o_trc_valid), 64'd0);

      // Full FIFO with simultaneous push and pop, then reset mid-drain.
      do_reset();
      for (int i = 1; i <= 16; i++) step(1'b1, 5'(i), 32'(i + 100), 1'b0);
      step(1'b1, 5'd17, 32'd117, 1'b1);
      chk("fullpp_drop", 64'(o_drop_count), 64'd0);
      step(1'b1, 5'd18, 32'd118, 1'b0);
      chk("fullpp_occ16", 64'(o_drop_count), 64'd1);
      repeat (3) step(1'b0, 5'd0, 32'd0, 1'b1);
      do_reset();
      chk("mid_rst_valid", 64'(o_trc_valid), 64'd0);
      chk("mid_rst_wr", 64'(o_wr_count), 64'd0);
      chk("mid_rst_drop", 64'(o_drop_count), 64'd0);

      // Randomized traffic with varying consumer throughput.
      for (int r = 0; r < 6; r++) begin
         do_reset();
         for (int c = 0; c < 140; c++) begin
            logic [4:0]      rrd;
            logic [XLEN-1:0] rdata;
            rrd   = ($urandom_range(0, 15) == 0) ? 5'd10 : 5'($urandom_range(0, 31));
            rdata = ($urandom_range(0, 9) == 0) ? 32'd1 : 32'($urandom);
            step($urandom_range(0, 3) != 0, rrd, rdata, $urandom_range(0, 5) < r);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv_wb_trace_monitor.md
Name: rv_wb_trace_monitor

Overview:
Synthesizable writeback monitor for the rv32i pipeline. It sits beside the register file and snoops every writeback. It replaces hierarchical register printing and a fixed end-of-sim delay with three things: a timestamped trace FIFO, a pass/timeout state machine, and event counters. A bench or debug port drains the trace through a valid/ready handshake.

Parameters:
XLEN, 32, writeback data width
DEPTH, 16, trace FIFO entries (power of 2, >=2)
CYC_W, 16, cycle-stamp / cycle-counter width
TIMEOUT_CYC, 100, RUN cycles before TIMEOUT (1 to 2^CYC_W-1)
DONE_REG, 10, register index whose write can end the test
DONE_VAL, 1, value written to DONE_REG that signals pass

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous active-high reset
i_wb_en  in  1  writeback valid this cycle
i_wb_rd  in  5  destination register index
i_wb_data  in  XLEN  writeback data
o_trc_valid  out  1  trace head valid (FIFO not empty)
i_trc_ready  in  1  consumer pops head when valid&ready
o_trc_rd  out  5  head entry rd
o_trc_data  out  XLEN  head entry data
o_trc_cycle  out  CYC_W  head entry cycle stamp
o_state  out  2  00 RUN, 01 DONE, 10 TIMEOUT (11 unused)
o_pass  out  1  state==DONE
o_wr_count  out  16  accepted writeback events, saturating
o_drop_count  out  8  events lost to full FIFO, saturating

Behaviour:
- One clock domain. Synchronous active-high reset, sampled on the rising edge of i_clk.
- Reset: state=RUN, cycle counter=0, FIFO empty (o_trc_valid=0). o_trc_rd/o_trc_data/o_trc_cycle=0, o_wr_count=0, o_drop_count=0, o_pass=0.
- Reset asserted mid-run or mid-drain clears everything above the same way. Any FIFO contents are discarded.
- Accepted event: i_wb_en=1, i_wb_rd!=0 and state==RUN. Writes to x0 and all writes outside RUN are ignored entirely (no push, no count).
- Cycle counter: increments by 1 every RUN cycle and freezes in DONE/TIMEOUT. An event's stamp is the counter value in the cycle it is sampled, so the first cycle after reset is stamp 0.
- FSM RUN->DONE: accepted event with rd==DONE_REG and data==DONE_VAL. The triggering event is itself pushed and counted.
- FSM RUN->TIMEOUT: counter==TIMEOUT_CYC-1 with no done event that cycle. If both happen in the same cycle, DONE wins.
- DONE and TIMEOUT are terminal until reset.
- FIFO: show-ahead, registered outputs. An event accepted in cycle N into an empty FIFO gives o_trc_valid=1 with its fields in cycle N+1.
- Pop occurs when o_trc_valid&i_trc_ready. The head then advances next cycle, or o_trc_valid drops if the FIFO is now empty.
- o_trc_* hold their value while o_trc_valid=1 and i_trc_ready=0.
- Push when full with no pop: the event is dropped, o_drop_count increments, o_wr_count still increments.
- Push and pop in the same cycle when full: both succeed and occupancy stays DEPTH.
- Push and pop in the same cycle when empty cannot occur (valid=0).
- Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.
- Draining works in every state, so the trace stays readable after DONE/TIMEOUT.
- Counters saturate at all-ones and never wrap.

Test Plan:
- Reset then idle with i_trc_ready=1: at cycle 99 state goes TIMEOUT (o_state=10), o_pass=0, o_trc_valid stays 0, o_wr_count=0.
- Writes x7=5 (cycle 2), x0=9 (cycle 3), x8=6 (cycle 4), ready=1: trace yields (7,5,2) then (8,6,4); o_wr_count=2; x0 never appears.
- Write x10=1 at cycle 20: o_state=01, o_pass=1 next cycle, entry (10,1,20) is in the trace. A later x9=3 write is ignored and the counter stays frozen at 21.
- Done write and counter==TIMEOUT_CYC-1 in the same cycle: state=DONE.
- Ready=0, 20 writes (x1..x20, data=rd): first 16 kept, o_drop_count=4, o_wr_count=20. Draining afterwards returns rd 1..16 in order, then valid=0.
- FIFO full, one write with ready=1 the same cycle: occupancy stays 16, no drop. Assert reset mid-drain: valid=0 and all counts are 0 the next cycle.
